// File: rtl/histo_sched_pkg.sv
// Shared types and default parameters for the histogram frame scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package histo_sched_pkg;

  localparam int SYNC_STAGES_DEF    = 2;
  localparam int TIMEOUT_CYCLES_DEF = 4000000;  // 32 ms at 125 MHz
  localparam int FRAME_ID_W_DEF     = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    WAIT_FV   = 3'd2,
    CAPTURE   = 3'd3,
    SEND      = 3'd4,
    WAIT_DONE = 3'd5
  } state_t;

endpackage

// File: rtl/histo_sched_edge_sync.sv
// Synchronizes an asynchronous level and emits a one-cycle registered rising-edge pulse.
// Latency: rise asserts SYNC_STAGES+1 cycles after async_in rises.
// Backpressure: none; every edge produces exactly one pulse.
module histo_sched_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;

  // Synchronizer chain, delayed copy of its output, and registered edge pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/histo_frame_scheduler.sv
// Sequences one camera frame per fsin trigger: arm, capture, histogram readout handshake.
// Latency: cam_en/histo_clear pulse SYNC_STAGES+2 cycles after fsin rises.
// Backpressure: send_req held until send_ack; extra triggers while busy are dropped and flagged.
module histo_frame_scheduler
  import histo_sched_pkg::*;
#(
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int FRAME_ID_W     = FRAME_ID_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fsin,
  input  logic                  frame_valid,
  input  logic                  send_ack,
  input  logic                  send_done,
  input  logic                  clear_errors,
  output logic                  cam_en,
  output logic                  histo_clear,
  output logic                  send_req,
  output logic [FRAME_ID_W-1:0] frame_id,
  output logic                  busy,
  output logic                  overrun,
  output logic                  timeout
);

  localparam int             WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic                  fsin_rise;
  state_t                state_q;
  logic [WD_W-1:0]       wd_q;
  logic [FRAME_ID_W-1:0] frame_id_q;
  logic                  fv_prev_q;
  logic                  cam_en_q;
  logic                  histo_clear_q;
  logic                  send_req_q;
  logic                  busy_q;
  logic                  overrun_q;
  logic                  timeout_q;

  histo_sched_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_fsin_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (fsin),
    .rise     (fsin_rise)
  );

  // Frame sequencer with watchdog, frame counter and sticky flags; all outputs registered.
  // The watchdog defaults to zero each cycle, so it clears on every state change and only
  // holds a count while parked in WAIT_FV or WAIT_DONE. busy tracks the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      wd_q          <= '0;
      frame_id_q    <= '0;
      fv_prev_q     <= 1'b0;
      cam_en_q      <= 1'b0;
      histo_clear_q <= 1'b0;
      send_req_q    <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      cam_en_q      <= 1'b0;
      histo_clear_q <= 1'b0;
      wd_q          <= '0;
      fv_prev_q     <= frame_valid;

      // Clear first so a simultaneous set below takes precedence.
      if (clear_errors) begin
        overrun_q <= 1'b0;
        timeout_q <= 1'b0;
      end
      // Triggers are never queued: outside IDLE they only raise the flag.
      if (fsin_rise && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (enable && fsin_rise) begin
            state_q       <= ARM;
            cam_en_q      <= 1'b1;
            histo_clear_q <= 1'b1;
            busy_q        <= 1'b1;
          end
        end
        ARM: begin
          state_q <= WAIT_FV;
        end
        WAIT_FV: begin
          // Only a fresh rising edge starts capture, so a frame already underway is skipped.
          if (frame_valid && !fv_prev_q) begin
            state_q <= CAPTURE;
          end else if (wd_q == WD_LAST) begin
            state_q   <= IDLE;
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        CAPTURE: begin
          if (!frame_valid && fv_prev_q) begin
            state_q    <= SEND;
            send_req_q <= 1'b1;
          end
        end
        SEND: begin
          if (send_ack) begin
            send_req_q <= 1'b0;
            if (send_done) begin
              state_q    <= IDLE;
              frame_id_q <= frame_id_q + FRAME_ID_W'(1);
              busy_q     <= 1'b0;
            end else begin
              state_q <= WAIT_DONE;
            end
          end
        end
        WAIT_DONE: begin
          if (send_done) begin
            state_q    <= IDLE;
            frame_id_q <= frame_id_q + FRAME_ID_W'(1);
            busy_q     <= 1'b0;
          end else if (wd_q == WD_LAST) begin
            state_q   <= IDLE;
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        default: begin
          state_q    <= IDLE;
          send_req_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign cam_en      = cam_en_q;
  assign histo_clear = histo_clear_q;
  assign send_req    = send_req_q;
  assign frame_id    = frame_id_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign timeout     = timeout_q;

endmodule
